// File: rtl/axi_write_arbiter.sv
// Round-robin write-channel arbiter: grants one master at a time and tracks the
// AW, W and B phases of its burst, with a watchdog for stalled transfers.
module axi_write_arbiter #(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_M-1:0]           m_AWVALID,
    input  logic [8*NUM_M-1:0]         m_AWLEN,
    input  logic                       s_AWREADY,
    input  logic                       s_WVALID,
    input  logic                       s_WREADY,
    input  logic                       s_WLAST,
    input  logic                       s_BVALID,
    input  logic                       s_BREADY,
    output logic [NUM_M-1:0]           wgrnt,
    output logic [$clog2(NUM_M)-1:0]   grant_id,
    output logic                       busy,
    output logic                       wlast_err,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_M);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] wgrnt_q, wgrnt_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [WDW-1:0]   wdog_q, wdog_d;

    logic             rr_found;
    logic [IDW-1:0]   rr_winner;
    logic [IDW-1:0]   rr_cand_idx;
    int               rr_cand;
    logic [7:0]       granted_len;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             wd_expired;

    // Search upward from the master after the last one served, wrapping at NUM_M.
    always_comb begin
        rr_found    = 1'b0;
        rr_winner   = '0;
        rr_cand     = 0;
        rr_cand_idx = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            rr_cand = int'(last_grant_q) + i;
            if (rr_cand >= NUM_M) begin
                rr_cand = rr_cand - NUM_M;
            end
            rr_cand_idx = IDW'(rr_cand);
            if (!rr_found && m_AWVALID[rr_cand_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand_idx;
            end
        end
    end

    always_comb begin
        granted_len = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_id_q == IDW'(i)) begin
                granted_len = m_AWLEN[i*8 +: 8];
            end
        end
    end

    assign aw_hs      = m_AWVALID[grant_id_q] & s_AWREADY;
    assign w_hs       = s_WVALID & s_WREADY;
    assign b_hs       = s_BVALID & s_BREADY;
    assign wd_expired = (wdog_q == WD_LAST) && !w_hs && !b_hs;

    always_comb begin
        state_d      = state_q;
        wgrnt_d      = wgrnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        wdog_d       = wdog_q;
        wlast_err    = 1'b0;
        timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                wgrnt_d    = '0;
                grant_id_d = '0;
                if (rr_found) begin
                    wgrnt_d    = NUM_M'(1) << rr_winner;
                    grant_id_d = rr_winner;
                    state_d    = ADDR;
                end
            end

            ADDR: begin
                if (aw_hs) begin
                    beat_cnt_d = granted_len;
                    wdog_d     = '0;
                    state_d    = DATA;
                end
            end

            DATA: begin
                // The burst length is fixed by AWLEN; WLAST is only cross-checked.
                if (w_hs) begin
                    wlast_err = s_WLAST != (beat_cnt_q == 8'd0);
                    if (beat_cnt_q == 8'd0) begin
                        state_d = RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
                if (w_hs || b_hs) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
                if (wd_expired) begin
                    timeout      = 1'b1;
                    last_grant_d = grant_id_q;
                    wgrnt_d      = '0;
                    grant_id_d   = '0;
                    wdog_d       = '0;
                    state_d      = IDLE;
                end
            end

            RESP: begin
                if (w_hs || b_hs) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
                if (b_hs || wd_expired) begin
                    timeout      = wd_expired;
                    last_grant_d = grant_id_q;
                    wgrnt_d      = '0;
                    grant_id_d   = '0;
                    wdog_d       = '0;
                    state_d      = IDLE;
                end
            end

            default: begin
                wgrnt_d    = '0;
                grant_id_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // last_grant resets to the top index so master 0 wins the first arbitration.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            wgrnt_q      <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_M - 1);
            beat_cnt_q   <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            wgrnt_q      <= wgrnt_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            wdog_q       <= wdog_d;
        end
    end

    assign wgrnt    = wgrnt_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: a transaction-level model is
// compared every cycle, plus directed literal checks for each scenario.
module tb_axi_write_arbiter;

    localparam int NUM_M   = 4;
    localparam int TIMEOUT = 16;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b0;
    logic [NUM_M-1:0]  m_AWVALID = '0;
    logic [8*NUM_M-1:0] m_AWLEN = '0;
    logic              s_AWREADY = 1'b0;
    logic              s_WVALID = 1'b0;
    logic              s_WREADY = 1'b0;
    logic              s_WLAST = 1'b0;
    logic              s_BVALID = 1'b0;
    logic              s_BREADY = 1'b0;
    logic [NUM_M-1:0]  wgrnt;
    logic [1:0]        grant_id;
    logic              busy;
    logic              wlast_err;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    axi_write_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .m_AWVALID(m_AWVALID),
        .m_AWLEN(m_AWLEN),
        .s_AWREADY(s_AWREADY),
        .s_WVALID(s_WVALID),
        .s_WREADY(s_WREADY),
        .s_WLAST(s_WLAST),
        .s_BVALID(s_BVALID),
        .s_BREADY(s_BREADY),
        .wgrnt(wgrnt),
        .grant_id(grant_id),
        .busy(busy),
        .wlast_err(wlast_err),
        .timeout(timeout)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level reference: who owns the bus, how many beats remain,
    // and how long since the last handshake.
    int m_owner = -1;
    int m_last  = NUM_M - 1;
    int m_left  = 0;
    int m_idle  = 0;
    bit m_aw    = 0;
    bit m_resp  = 0;
    bit m_w, m_b, m_was_resp;

    function automatic int pickNext(input logic [NUM_M-1:0] req, input int last);
        for (int i = 1; i <= NUM_M; i++) begin
            if (req[(last + i) % NUM_M]) return (last + i) % NUM_M;
        end
        return -1;
    endfunction

    function automatic int lenOf(input int m);
        logic [7:0] b;
        b = m_AWLEN[m*8 +: 8];
        return int'(b);
    endfunction

    task automatic modelRelease();
        m_last  = m_owner;
        m_owner = -1;
        m_aw    = 0;
        m_resp  = 0;
        m_idle  = 0;
    endtask

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_owner = -1;
            m_last  = NUM_M - 1;
            m_aw    = 0;
            m_resp  = 0;
            m_left  = 0;
            m_idle  = 0;
        end else if (m_owner < 0) begin
            m_owner = pickNext(m_AWVALID, m_last);
        end else if (!m_aw) begin
            if (m_AWVALID[m_owner] && s_AWREADY) begin
                m_aw   = 1;
                m_left = lenOf(m_owner) + 1;
                m_idle = 0;
            end
        end else begin
            m_w        = s_WVALID && s_WREADY;
            m_b        = s_BVALID && s_BREADY;
            m_was_resp = m_resp;
            if (!m_was_resp && m_w) begin
                m_left--;
                if (m_left == 0) m_resp = 1;
            end
            if ((m_was_resp && m_b) || (!m_w && !m_b && m_idle == TIMEOUT - 1)) begin
                modelRelease();
            end else if (m_w || m_b) begin
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    end

    int wlePulses = 0;
    int toPulses  = 0;
    int grantLog[$];
    int gapLog[$];
    int gapCnt = 0;
    bit haveGrant = 0;
    logic [NUM_M-1:0] prevGrnt = '0;

    always @(negedge ACLK) begin
        bit ew, eb;
        if (!ARESET) begin
            ew = s_WVALID && s_WREADY;
            eb = s_BVALID && s_BREADY;
            checkOutput("mdl_wgrnt", int'(wgrnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            checkOutput("mdl_grant_id", int'(grant_id), (m_owner >= 0) ? m_owner : 0);
            checkOutput("mdl_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
            checkOutput("mdl_wlast_err", int'(wlast_err),
                        (m_aw && !m_resp && ew && (s_WLAST != (m_left == 1))) ? 1 : 0);
            checkOutput("mdl_timeout", int'(timeout),
                        (m_aw && !ew && !eb && m_idle == TIMEOUT - 1) ? 1 : 0);
            if (wlast_err) wlePulses++;
            if (timeout) toPulses++;
            if (wgrnt == '0) begin
                gapCnt++;
            end else if (prevGrnt == '0) begin
                if (haveGrant) gapLog.push_back(gapCnt);
                grantLog.push_back(int'(grant_id));
                haveGrant = 1;
                gapCnt    = 0;
            end
        end
        prevGrnt = wgrnt;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_M-1:0] awv, input logic awr,
                                 input logic wv, input logic wr, input logic wl,
                                 input logic bv, input logic br);
        m_AWVALID = awv;
        s_AWREADY = awr;
        s_WVALID  = wv;
        s_WREADY  = wr;
        s_WLAST   = wl;
        s_BVALID  = bv;
        s_BREADY  = br;
    endtask

    task automatic setLen(input int m, input int len);
        m_AWLEN[m*8 +: 8] = 8'(len);
    endtask

    task automatic applyReset();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        ARESET = 1'b1;
        @(negedge ACLK);
        checkOutput("rst_wgrnt", int'(wgrnt), 0);
        checkOutput("rst_grant_id", int'(grant_id), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_wlast_err", int'(wlast_err), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        tick();
        ARESET = 1'b0;
    endtask

    int expOrder[5] = '{0, 1, 2, 3, 0};
    int toCycle;

    initial begin
        #2;
        $display("[TB] single master burst");
        applyReset();
        m_AWLEN = '0;
        setLen(2, 3);
        wlePulses = 0;
        applyStimulus(4'b0100, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge ACLK);
        checkOutput("t1_wgrnt", int'(wgrnt), 4);
        checkOutput("t1_grant_id", int'(grant_id), 2);
        tick();
        applyStimulus('0, 0, 1, 1, 0, 0, 0);
        repeat (3) tick();
        applyStimulus('0, 0, 0, 0, 0, 1, 1);
        tick();
        @(negedge ACLK);
        checkOutput("t1_held_after_beat3", int'(busy), 1);
        applyStimulus('0, 0, 1, 1, 1, 0, 0);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 1, 1);
        @(negedge ACLK);
        checkOutput("t1_resp_busy", int'(busy), 1);
        checkOutput("t1_resp_wgrnt", int'(wgrnt), 4);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t1_end_wgrnt", int'(wgrnt), 0);
        checkOutput("t1_end_busy", int'(busy), 0);
        checkOutput("t1_wlast_err_count", wlePulses, 0);

        $display("[TB] round-robin fairness");
        applyReset();
        m_AWLEN = '0;
        grantLog.delete();
        gapLog.delete();
        haveGrant = 0;
        applyStimulus(4'b1111, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 100 && grantLog.size() < 5; i++) tick();
        applyStimulus('0, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 20 && busy; i++) tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t2_done_busy", int'(busy), 0);
        checkOutput("t2_grant_count", grantLog.size(), 5);
        for (int k = 0; k < grantLog.size() && k < 5; k++)
            checkOutput($sformatf("t2_order_%0d", k), grantLog[k], expOrder[k]);
        checkOutput("t2_gap_count", gapLog.size(), 4);
        for (int k = 0; k < gapLog.size(); k++)
            checkOutput($sformatf("t2_gap_%0d", k), gapLog[k], 1);

        $display("[TB] wlast error");
        wlePulses = 0;
        setLen(3, 1);
        applyStimulus(4'b1000, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge ACLK);
        checkOutput("t3_grant_id", int'(grant_id), 3);
        tick();
        applyStimulus('0, 0, 1, 1, 1, 0, 0);
        @(negedge ACLK);
        checkOutput("t3_wle_beat1", int'(wlast_err), 1);
        tick();
        applyStimulus('0, 0, 1, 1, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t3_wle_beat2", int'(wlast_err), 1);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t3_resp_busy", int'(busy), 1);
        applyStimulus('0, 0, 0, 0, 0, 1, 1);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t3_end_busy", int'(busy), 0);
        checkOutput("t3_wle_count", wlePulses, 2);

        $display("[TB] watchdog timeout");
        toPulses = 0;
        applyStimulus(4'b0010, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge ACLK);
        checkOutput("t4_grant_id", int'(grant_id), 1);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        toCycle = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge ACLK);
            if (timeout && toCycle == 0) toCycle = c;
        end
        checkOutput("t4_timeout_cycle", toCycle, 16);
        tick();
        @(negedge ACLK);
        checkOutput("t4_idle_busy", int'(busy), 0);
        checkOutput("t4_idle_wgrnt", int'(wgrnt), 0);
        checkOutput("t4_timeout_count", toPulses, 1);
        setLen(2, 4);
        applyStimulus(4'b0110, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge ACLK);
        checkOutput("t4_next_grant", int'(grant_id), 2);

        $display("[TB] async reset mid-burst");
        tick();
        applyStimulus('0, 0, 1, 1, 0, 0, 0);
        tick();
        #1 ARESET = 1'b1;
        #1;
        checkOutput("t5_rst_wgrnt", int'(wgrnt), 0);
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_grant_id", int'(grant_id), 0);
        #1 ARESET = 1'b0;
        m_AWLEN = '0;
        setLen(0, 255);
        applyStimulus(4'b1001, 1, 0, 0, 0, 0, 0);
        tick();
        @(negedge ACLK);
        checkOutput("t5_grant_wgrnt", int'(wgrnt), 1);
        checkOutput("t5_grant_id", int'(grant_id), 0);

        $display("[TB] maximum burst");
        wlePulses = 0;
        tick();
        applyStimulus('0, 0, 1, 1, 0, 0, 0);
        repeat (255) tick();
        applyStimulus('0, 0, 1, 1, 1, 0, 0);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t6_resp_busy", int'(busy), 1);
        applyStimulus('0, 0, 0, 0, 0, 1, 1);
        tick();
        applyStimulus('0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("t6_end_busy", int'(busy), 0);
        checkOutput("t6_wle_count", wlePulses, 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameter NUM_M, default 4: number of requesting masters; range 2..8.
REQ-002 Parameter TIMEOUT, default 256: idle-handshake cycles in DATA or RESP before the transaction is aborted; range 2..65536.
REQ-003 ACLK  in  1  single clock; all state changes on its rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 m_AWVALID  in  NUM_M  per-master write-address request; bit i belongs to master i.
REQ-006 m_AWLEN  in  8*NUM_M  per-master AWLEN; byte i belongs to master i.
REQ-007 s_AWREADY  in  1  AWREADY from the addressed slave, already muxed.
REQ-008 s_WVALID, s_WREADY, s_WLAST  in  1 each  muxed W-channel handshake and last flag.
REQ-009 s_BVALID, s_BREADY  in  1 each  muxed B-channel handshake.
REQ-010 wgrnt  out  NUM_M  one-hot write grant, driving the master/slave muxes.
REQ-011 grant_id  out  clog2(NUM_M)  index of the granted master; 0 when no grant.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 wlast_err  out  1  one-cycle pulse when WLAST disagrees with the beat count.
REQ-014 timeout  out  1  one-cycle pulse when a transaction is aborted by the watchdog.

Function
REQ-015 The FSM SHALL have four states: IDLE, ADDR, DATA and RESP.
REQ-016 In IDLE with any m_AWVALID bit set, the arbiter SHALL pick a winner by round-robin, searching upward from (last_grant+1) mod NUM_M.
- It SHALL register the winner into wgrnt/grant_id and move to ADDR.
- wgrnt is therefore high from the cycle after the request is seen.
REQ-017 In IDLE with no request, wgrnt SHALL be all-zero and the state SHALL remain IDLE.
REQ-018 In ADDR, when m_AWVALID[grant_id] & s_AWREADY, the arbiter SHALL:
- load beat_cnt with m_AWLEN[grant_id];
- clear the watchdog;
- move to DATA.
REQ-019 ADDR SHALL NOT time out; the grant SHALL be held until the AW handshake.
REQ-020 In DATA, each s_WVALID & s_WREADY SHALL decrement beat_cnt.
- On the handshake where beat_cnt == 0, the FSM SHALL move to RESP.
REQ-021 On any DATA-state W handshake, wlast_err SHALL pulse if s_WLAST != (beat_cnt == 0).
- The burst SHALL still end on the count, not on WLAST.
REQ-022 In RESP, s_BVALID & s_BREADY SHALL:
- set last_grant to grant_id;
- clear wgrnt;
- move to IDLE.
REQ-023 A new grant SHALL be issued no earlier than the cycle after the arbiter returns to IDLE, so at least one cycle with wgrnt == 0 separates successive grants.
REQ-024 The watchdog SHALL count cycles in DATA and RESP and SHALL clear on every W or B handshake.
- On reaching TIMEOUT-1 without a handshake, it SHALL pulse timeout.
- It SHALL then update last_grant to grant_id, clear wgrnt and return to IDLE.
REQ-025 wgrnt SHALL be one-hot or zero at all times, and grant_id SHALL equal the index of the set bit.
REQ-026 A master deasserting m_AWVALID in ADDR is ignored: the grant SHALL be held.
REQ-027 Requests arriving outside IDLE SHALL have no effect until the arbiter returns to IDLE.
REQ-028 AWLEN = 0 SHALL give a single-beat burst: DATA is left on the first W handshake.
REQ-029 AWLEN = 255 SHALL give 256 beats, using an 8-bit counter that never wraps.

Reset
REQ-030 While ARESET is high, the outputs and state SHALL be held as follows:
- state = IDLE;
- wgrnt = 0, grant_id = 0;
- busy = 0, wlast_err = 0, timeout = 0;
- beat_cnt = 0, watchdog = 0;
- last_grant = NUM_M-1, so master 0 has first priority.
REQ-031 ARESET asserted mid-transaction SHALL force the reset values immediately, without waiting for the clock.
- After release, arbitration SHALL restart from master 0 priority.

Verification
REQ-032 Single master: m_AWVALID = 0b0100, AWLEN = 3, four W beats with WLAST on the 4th, then B -> wgrnt = 0b0100, grant_id = 2; RESP entered after beat 4; wgrnt = 0 after B; no wlast_err.
REQ-033 Fairness: all four m_AWVALID held high, AWLEN = 0 each -> grant order 0,1,2,3,0; each grant separated by one cycle of wgrnt = 0.
REQ-034 WLAST error: AWLEN = 1, WLAST on beat 1 -> wlast_err pulses on beat 1, and again on beat 2 (WLAST low); RESP entered after beat 2.
REQ-035 Timeout: TIMEOUT = 16, grant to master 1, AW done, s_WVALID held low -> timeout pulses in the 16th DATA cycle; IDLE next; the following grant goes to master 2 if it requests.
REQ-036 Async reset: ARESET pulsed mid-DATA between clock edges -> wgrnt = 0 and busy = 0 immediately; the next request from masters 0 and 3 grants master 0.
REQ-037 Max burst: AWLEN = 255, WLAST on beat 256 -> exactly 256 beats accepted; no wlast_err; RESP entered.
